// File: rtl/lcd_char_driver_if.sv
// Register-file read port plus HD44780 panel pins, driven by lcd_char_driver.
// No latency of its own; the panel has no backpressure, only fixed cycle timing.
interface lcd_char_driver_if;
    logic [4:0] sel;
    logic [7:0] char_in;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_db;
    logic       init_done;
    logic       frame_done;

    modport master (
        output sel, lcd_e, lcd_rs, lcd_rw, lcd_db, init_done, frame_done,
        input  char_in
    );

    modport slave (
        input  sel, lcd_e, lcd_rs, lcd_rw, lcd_db, init_done, frame_done,
        output char_in
    );
endinterface

// File: rtl/lcd_char_driver.sv
// Initialises a 16x2 HD44780 panel in 8-bit mode, then refreshes it from the 32-entry char file.
// Latency: byte period 1+T_SETUP+T_E+T_WAIT (T_CLEAR for clear); no backpressure, busy flag is never read.
module lcd_char_driver #(
    parameter int T_POWERUP = 750000,
    parameter int T_SETUP   = 2,
    parameter int T_E       = 12,
    parameter int T_WAIT    = 2000,
    parameter int T_CLEAR   = 82000
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_char_driver_if.master  bus
);

    typedef enum logic [2:0] {PWR, LOAD, SETUP, EHI, WAIT} phase_t;

    // Byte sequence: steps 0-3 init commands, 4 = line-1 address, 5-20 chars 0-15,
    // 21 = line-2 address, 22-37 chars 16-31, then back to 4.
    localparam logic [5:0]  STEP_CLEAR = 6'd2;
    localparam logic [5:0]  STEP_ADDR1 = 6'd4;
    localparam logic [5:0]  STEP_ADDR2 = 6'd21;
    localparam logic [5:0]  STEP_LAST  = 6'd37;
    localparam logic [19:0] PWR_END    = 20'(T_POWERUP - 1);
    localparam logic [19:0] SETUP_END  = 20'(T_SETUP - 1);
    localparam logic [19:0] E_END      = 20'(T_E - 1);
    localparam logic [19:0] WAIT_END   = 20'(T_WAIT - 1);
    localparam logic [19:0] CLEAR_END  = 20'(T_CLEAR - 1);

    phase_t      state, state_nxt;
    logic [19:0] cnt, cnt_nxt;
    logic [5:0]  step, step_nxt;
    logic [19:0] wait_end;
    logic        frame_end;

    logic [4:0]  sel_q;
    logic        e_q;
    logic        rs_q;
    logic [7:0]  db_q;
    logic        init_q;
    logic        frame_q;

    function automatic logic is_data(input logic [5:0] s);
        return (s > STEP_ADDR1) && (s != STEP_ADDR2);
    endfunction

    function automatic logic [4:0] char_idx(input logic [5:0] s);
        return (s < STEP_ADDR2) ? 5'(s - 6'd5) : 5'(s - 6'd6);
    endfunction

    function automatic logic [7:0] cmd_byte(input logic [5:0] s);
        logic [7:0] b;
        case (s)
            6'd0:       b = 8'h38;
            6'd1:       b = 8'h0C;
            6'd2:       b = 8'h01;
            6'd3:       b = 8'h06;
            STEP_ADDR1: b = 8'h80;
            default:    b = 8'hC0;
        endcase
        return b;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 20'd1;
        step_nxt  = step;
        wait_end  = (step == STEP_CLEAR) ? CLEAR_END : WAIT_END;
        unique case (state)
            PWR: if (cnt == PWR_END) begin
                state_nxt = LOAD;
                cnt_nxt   = '0;
            end
            LOAD: begin
                state_nxt = SETUP;
                cnt_nxt   = '0;
            end
            SETUP: if (cnt == SETUP_END) begin
                state_nxt = EHI;
                cnt_nxt   = '0;
            end
            EHI: if (cnt == E_END) begin
                state_nxt = WAIT;
                cnt_nxt   = '0;
            end
            WAIT: if (cnt == wait_end) begin
                state_nxt = LOAD;
                cnt_nxt   = '0;
                step_nxt  = (step == STEP_LAST) ? STEP_ADDR1 : step + 6'd1;
            end
            default: begin
                state_nxt = PWR;
                cnt_nxt   = '0;
            end
        endcase
        // Registered from next-state so the pulse lands on the final WAIT cycle of char 31.
        frame_end = (state_nxt == WAIT) && (step_nxt == STEP_LAST) && (cnt_nxt == WAIT_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PWR;
            cnt   <= '0;
            step  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            step  <= step_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= '0;
            init_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            e_q     <= (state_nxt == EHI);
            frame_q <= frame_end;
            init_q  <= (step >= STEP_ADDR1);
            if (state != LOAD && state_nxt == LOAD && is_data(step_nxt))
                sel_q <= char_idx(step_nxt);
            // char_in is only sampled here, so later file writes wait for the next visit.
            if (state == LOAD && state_nxt == SETUP) begin
                rs_q <= is_data(step);
                db_q <= is_data(step) ? bus.char_in : cmd_byte(step);
            end
        end
    end

    assign bus.sel        = sel_q;
    assign bus.lcd_e      = e_q;
    assign bus.lcd_rs     = rs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_db     = db_q;
    assign bus.init_done  = init_q;
    assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_lcd_char_driver.sv
// Directed bench for lcd_char_driver with short panel timings and a modelled char file.
module tb_lcd_char_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] regfile [32];
    logic [7:0] glitch = 8'h00;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rel0 = 0;
    int last_rise = 0;
    int id_cyc = -1;
    int fd_cyc [8];
    int fd_n = 0;

    lcd_char_driver_if bus ();

    lcd_char_driver #(
        .T_POWERUP (10),
        .T_SETUP   (1),
        .T_E       (2),
        .T_WAIT    (3),
        .T_CLEAR   (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.char_in = regfile[bus.sel] ^ glitch;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) id_cyc = -1;
        else if (bus.init_done && id_cyc < 0) id_cyc = cyc;
    end

    always @(negedge clk) begin
        if (bus.frame_done) begin
            if (fd_n < 8) fd_cyc[fd_n] = cyc;
            fd_n = fd_n + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits for the next E pulse and checks its byte, setup, width, hold and spacing.
    task automatic get_pulse(input string tag, input logic [7:0] edb, input logic ers,
                             input int esel, input int eper, input bit glitch_it);
        logic [7:0] pdb;
        logic       prs;
        int         n;
        int         w;
        int         rise;
        bit         hold_ok;
        n   = 0;
        pdb = bus.lcd_db;
        prs = bus.lcd_rs;
        while (!bus.lcd_e && n < 300) begin
            pdb = bus.lcd_db;
            prs = bus.lcd_rs;
            tick();
            n++;
        end
        if (!bus.lcd_e) begin
            chk({tag, " e timeout"}, 32'd0, 32'd1);
            return;
        end
        rise = cyc - rel0;
        if (eper > 0) chk({tag, " period"}, rise - last_rise, eper);
        last_rise = rise;
        chk({tag, " db"}, bus.lcd_db, edb);
        chk({tag, " rs"}, bus.lcd_rs, ers);
        chk({tag, " setup"}, {prs, pdb}, {ers, edb});
        if (esel >= 0) chk({tag, " sel"}, bus.sel, esel);
        if (glitch_it) glitch = 8'hFF;
        w = 0;
        while (bus.lcd_e && w < 20) begin
            tick();
            w++;
        end
        glitch = 8'h00;
        chk({tag, " e width"}, w, 2);
        hold_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            if (bus.lcd_e || bus.lcd_db !== edb || bus.lcd_rs !== ers || bus.lcd_rw !== 1'b0)
                hold_ok = 1'b0;
        end
        chk({tag, " hold"}, hold_ok, 1'b1);
    endtask

    // Power-up wait of 10 cycles, then E rises 12 edges after release (LOAD + SETUP);
    // init_done: 10 + 3*7 + 10 + 1 = 42 edges after release.
    task automatic run_init;
        bit quiet;
        @(negedge clk);
        rst_n     = 1'b1;
        rel0      = cyc;
        last_rise = 0;
        quiet     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.lcd_e) quiet = 1'b0;
        end
        chk("powerup e quiet", quiet, 1'b1);
        get_pulse("init 38", 8'h38, 1'b0, 0, 0, 1'b0);
        chk("init first rise", last_rise, 12);
        get_pulse("init 0c", 8'h0C, 1'b0, 0, 7, 1'b0);
        get_pulse("init 01", 8'h01, 1'b0, 0, 7, 1'b0);
        get_pulse("init 06", 8'h06, 1'b0, 0, 10, 1'b0);
        tick();
        @(negedge clk);
        #1;
        chk("init_done cycle", id_cyc - rel0, 42);
    endtask

    task automatic run_frame(input int f);
        logic [7:0] e;
        get_pulse($sformatf("f%0d addr1", f), 8'h80, 1'b0, (f == 1) ? 0 : 31, 7, 1'b0);
        for (int k = 0; k < 32; k++) begin
            if (k == 16) get_pulse($sformatf("f%0d addr2", f), 8'hC0, 1'b0, 15, 7, 1'b0);
            e = 8'h41 + 8'(k);
            if (k == 5 && f >= 2) e = 8'h7A;
            get_pulse($sformatf("f%0d c%0d", f, k), e, 1'b1, k, 7, (f == 2 && k == 10));
            if (f == 1 && k == 5) regfile[5] = 8'h7A;
        end
    endtask

    initial begin
        int n;
        for (int k = 0; k < 32; k++) regfile[k] = 8'h41 + 8'(k);
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst sel", bus.sel, 5'd0);
        chk("rst e", bus.lcd_e, 1'b0);
        chk("rst rs", bus.lcd_rs, 1'b0);
        chk("rst rw", bus.lcd_rw, 1'b0);
        chk("rst db", bus.lcd_db, 8'h00);
        chk("rst init_done", bus.init_done, 1'b0);
        chk("rst frame_done", bus.frame_done, 1'b0);

        run_init();
        run_frame(1);
        run_frame(2);
        run_frame(3);

        // First frame: ADDR1 starts at cycle 41, last WAIT cycle of char 31 is 41 + 238 - 1.
        chk("frame_done count", fd_n, 3);
        chk("frame_done 1 cycle", fd_cyc[0] - rel0, 278);
        chk("frame_done spacing 1-2", fd_cyc[1] - fd_cyc[0], 238);
        chk("frame_done spacing 2-3", fd_cyc[2] - fd_cyc[1], 238);

        get_pulse("f4 addr1", 8'h80, 1'b0, 31, 7, 1'b0);
        for (int k = 0; k < 3; k++)
            get_pulse($sformatf("f4 c%0d", k), 8'h41 + 8'(k), 1'b1, k, 7, 1'b0);
        n = 0;
        while (!bus.lcd_e && n < 50) begin
            tick();
            n++;
        end
        chk("c3 in ehi", bus.lcd_e, 1'b1);
        chk("c3 sel", bus.sel, 5'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst e", bus.lcd_e, 1'b0);
        chk("arst db", bus.lcd_db, 8'h00);
        chk("arst rs", bus.lcd_rs, 1'b0);
        chk("arst sel", bus.sel, 5'd0);
        chk("arst init_done", bus.init_done, 1'b0);
        chk("arst frame_done", bus.frame_done, 1'b0);
        repeat (3) tick();

        run_init();
        get_pulse("post-reset addr1", 8'h80, 1'b0, 0, 7, 1'b0);
        get_pulse("post-reset c0", 8'h41, 1'b1, 0, 7, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
